regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the next processor datapath: NUM_RD registered read
//  ports and two write ports (writeback + load return), with same-cycle write-to-read bypass.
//  Adds a per-register busy scoreboard (reserve at issue, clear at writeback) reported with read
//  data so the issue stage can detect RAW hazards. Sits between decode/issue and writeback.
// PARAMETERS
//  DATA_W    32                  register width in bits
//  NUM_REGS  32                  number of architectural registers (>=2)
//  ADDR_W    $clog2(NUM_REGS)    register address width
//  NUM_RD    2                   number of read ports (1..4)
//  ZERO_REG  1                   1: register 0 reads 0, ignores writes and reserves
//  BYPASS    1                   1: same-cycle write data forwarded to read; 0: old value returned
// PORTS
//  clk       in   1              clock, all state updates on rising edge
//  rst       in   1              synchronous active-high reset
//  rd_en     in   NUM_RD         read request per port
//  rd_addr   in   NUM_RD*ADDR_W  read address, port i at [i*ADDR_W +: ADDR_W]
//  rd_data   out  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
//  rd_valid  out  NUM_RD         rd_data[i] updated this cycle
//  rd_busy   out  NUM_RD         register read on port i is reserved (result pending)
//  wr0_en    in   1              write port 0 enable
//  wr0_addr  in   ADDR_W         write port 0 address
//  wr0_data  in   DATA_W         write port 0 data
//  wr1_en    in   1              write port 1 enable
//  wr1_addr  in   ADDR_W         write port 1 address
//  wr1_data  in   DATA_W         write port 1 data
//  rsv_en    in   1              reserve request: mark rsv_addr busy
//  rsv_addr  in   ADDR_W         register to reserve
// BEHAVIOUR
//  Clock clk, reset rst: one clock; reset is synchronous and active-high.
//  Reset: all registers 0, all busy bits 0, rd_data 0, rd_valid 0, rd_busy 0. Reset overrides every
//   same-cycle write/reserve/read. No other reset behaviour; a read issued with rst high is dropped.
//  Write: on edge with wrX_en, reg[wrX_addr] <= wrX_data and busy[wrX_addr] <= 0.
//   Both ports same address: port 1 wins data. Different addresses: both commit.
//   ZERO_REG=1 and address 0: write dropped. Address >= NUM_REGS: write dropped.
//  Read: latency 1. On edge with rd_en[i]: rd_data[i] <= value, rd_valid[i] <= 1, rd_busy[i] <= busy.
//   rd_en[i]=0: rd_valid[i] <= 0, rd_data[i] and rd_busy[i] hold previous value.
//   value: 0 if ZERO_REG=1 and addr 0, or addr >= NUM_REGS; else, with BYPASS=1 and a same-cycle
//   write to that addr, the winning write data (port 1 over port 0); else stored reg contents.
//   BYPASS=0: stored contents before the edge.
//  Ports are independent; any number may read the same address in the same cycle.
//  Scoreboard: rsv_en sets busy[rsv_addr] on the edge. Same cycle, same addr as a write: reserve wins
//   (bit ends 1; new producer). ZERO_REG=1 and addr 0, or out-of-range addr: reserve ignored.
//  rd_busy[i] samples the busy bit after that edge's updates, i.e. reflects same-cycle
//   write-clear and reserve. Out-of-range/zero-reg reads report busy 0.
//  Busy bits with no write pending stay set until a write or reset; no timeout.
// TESTING
//  rst 1 cycle, read ports 0..NUM_RD-1 addr 5 -> next cycle rd_data 0, rd_valid 1, rd_busy 0.
//  wr0 addr 3 data 32'hDEAD_BEEF, same cycle rd port 0 addr 3 -> next cycle rd_data 32'hDEAD_BEEF
//   (BYPASS=1); BYPASS=0 build -> 0.
//  wr0 addr 7 = 32'h1111, wr1 addr 7 = 32'h2222 same cycle -> later read addr 7 returns 32'h2222.
//  wr0 addr 0 data 32'hFFFF_FFFF, rsv addr 0 -> read addr 0 returns 0, rd_busy 0 (ZERO_REG=1).
//  rsv addr 9 -> read addr 9 rd_busy 1; wr1 addr 9 = 32'h42 with read addr 9 -> rd_data 32'h42,
//   rd_busy 0; rsv + wr0 addr 9 same cycle -> rd_busy 1.
//  Fill regs 1..31 with index, assert rst mid-stream with rd_en=1 -> next cycle rd_valid 0, all reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two write ports with optional
// write-to-read bypass, and a per-register busy scoreboard for RAW hazard detection.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr
);

    localparam logic [ADDR_W:0] REGS_LIM = (ADDR_W + 1)'(NUM_REGS);

    // An address is "live" when it maps to a real, writable register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < REGS_LIM) && !(ZERO_REG && (a == '0));
    endfunction

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                wr0_ok;
    logic                wr1_ok;
    logic                rsv_ok;

    logic [ADDR_W-1:0]   rd_addr_a    [NUM_RD];
    logic [DATA_W-1:0]   rd_value     [NUM_RD];
    logic [NUM_RD-1:0]   rd_busy_next;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_addr
        assign rd_addr_a[g] = rd_addr[g*ADDR_W +: ADDR_W];
    end

    assign wr0_ok = wr0_en && addr_ok(wr0_addr);
    assign wr1_ok = wr1_en && addr_ok(wr1_addr);
    assign rsv_ok = rsv_en && addr_ok(rsv_addr);

    // Reserve is applied last so a new producer outranks a same-cycle writeback.
    always_comb begin
        // NOTE: default first so every path assigns the whole vector; otherwise a latch is inferred.
        busy_next = busy;
        if (wr0_ok) busy_next[wr0_addr] = 1'b0;
        if (wr1_ok) busy_next[wr1_addr] = 1'b0;
        if (rsv_ok) busy_next[rsv_addr] = 1'b1;
    end

    // NOTE: blocking '=' here lets the later wr1 match override the wr0 match within the same pass.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_value[i]     = '0;
            rd_busy_next[i] = 1'b0;
            if (addr_ok(rd_addr_a[i])) begin
                rd_value[i]     = regs[rd_addr_a[i]];
                rd_busy_next[i] = busy_next[rd_addr_a[i]];
                if (BYPASS) begin
                    if (wr0_ok && (wr0_addr == rd_addr_a[i])) rd_value[i] = wr0_data;
                    if (wr1_ok && (wr1_addr == rd_addr_a[i])) rd_value[i] = wr1_data;
                end
            end
        end
    end

    // NOTE: the register array itself is reset because software expects every register to read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            busy     <= '0;
            rd_data  <= '0;
            rd_valid <= '0;
            rd_busy  <= '0;
        end else begin
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
            busy <= busy_next;
            for (int i = 0; i < NUM_RD; i++) begin
                rd_valid[i] <= rd_en[i];
                if (rd_en[i]) begin
                    rd_data[i*DATA_W +: DATA_W] <= rd_value[i];
                    rd_busy[i]                  <= rd_busy_next[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against a behavioural model of the register file and scoreboard.
module tb_regfile_mp;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam bit ZERO_REG = 1'b1;
    localparam bit BYPASS   = 1'b1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;

    int errors = 0;
    int checks = 0;

    // Behavioural model: architectural state plus the outputs expected after the last edge.
    logic [DATA_W-1:0] m_reg  [NUM_REGS];
    bit                m_busy [NUM_REGS];
    logic [DATA_W-1:0] exp_data  [NUM_RD];
    bit                exp_valid [NUM_RD];
    bit                exp_busy  [NUM_RD];

    regfile_mp #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
        .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit live(input int a);
        return (a < NUM_REGS) && !(ZERO_REG && a == 0);
    endfunction

    function automatic logic [DATA_W-1:0] port_data(input int i);
        return rd_data[i*DATA_W +: DATA_W];
    endfunction

    task automatic idle();
        rst = 0; rd_en = '0; rd_addr = '0;
        wr0_en = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_addr = '0; wr1_data = '0;
        rsv_en = 0; rsv_addr = '0;
    endtask

    task automatic set_read(input int port, input int addr);
        rd_en[port] = 1'b1;
        rd_addr[port*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    // Advance one clock, moving the model forward under the currently driven inputs.
    task automatic cycle();
        logic [DATA_W-1:0] old_reg [NUM_REGS];
        int a;
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin m_reg[r] = '0; m_busy[r] = 0; end
            for (int i = 0; i < NUM_RD; i++) begin exp_data[i] = '0; exp_valid[i] = 0; exp_busy[i] = 0; end
        end else begin
            old_reg = m_reg;
            if (wr0_en && live(int'(wr0_addr))) begin m_reg[wr0_addr] = wr0_data; m_busy[wr0_addr] = 0; end
            if (wr1_en && live(int'(wr1_addr))) begin m_reg[wr1_addr] = wr1_data; m_busy[wr1_addr] = 0; end
            if (rsv_en && live(int'(rsv_addr))) m_busy[rsv_addr] = 1;
            for (int i = 0; i < NUM_RD; i++) begin
                exp_valid[i] = rd_en[i];
                if (rd_en[i]) begin
                    a = int'(rd_addr[i*ADDR_W +: ADDR_W]);
                    // With bypass a read sees the post-edge contents; without it, the pre-edge ones.
                    exp_data[i] = !live(a) ? '0 : (BYPASS ? m_reg[a] : old_reg[a]);
                    exp_busy[i] = live(a) ? m_busy[a] : 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        for (int i = 0; i < NUM_RD; i++) set_read(i, 5);
        cycle();
        for (int i = 0; i < NUM_RD; i++) begin
            checks++;
            if (rd_valid[i] !== 1'b0 || port_data(i) !== '0 || rd_busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state port%0d: got valid=%b data=%h busy=%b, want 0/0/0",
                         i, rd_valid[i], port_data(i), rd_busy[i]);
            end
        end
        rst = 0;
        cycle();
        for (int i = 0; i < NUM_RD; i++) begin
            checks++;
            if (rd_valid[i] !== 1'b1 || port_data(i) !== '0 || rd_busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL read_after_reset port%0d: got valid=%b data=%h busy=%b, want 1/0/0",
                         i, rd_valid[i], port_data(i), rd_busy[i]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] want;
        idle();
        wr0_en = 1; wr0_addr = 5'd3; wr0_data = 32'hDEAD_BEEF;
        set_read(0, 3);
        cycle();
        want = BYPASS ? 32'hDEAD_BEEF : 32'h0;
        checks++;
        if (port_data(0) !== want) begin
            errors++;
            $display("FAIL bypass: got %h, want %h", port_data(0), want);
        end
        idle();
        set_read(1, 3);
        cycle();
        checks++;
        if (port_data(1) !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL stored_after_write: got %h, want deadbeef", port_data(1));
        end
    endtask

    task automatic test_same_addr();
        idle();
        wr0_en = 1; wr0_addr = 5'd7; wr0_data = 32'h1111;
        wr1_en = 1; wr1_addr = 5'd7; wr1_data = 32'h2222;
        cycle();
        idle();
        for (int i = 0; i < NUM_RD; i++) set_read(i, 7);
        cycle();
        for (int i = 0; i < NUM_RD; i++) begin
            checks++;
            if (port_data(i) !== 32'h2222) begin
                errors++;
                $display("FAIL wr1_wins port%0d: got %h, want 2222", i, port_data(i));
            end
        end
    endtask

    task automatic test_zero_reg();
        idle();
        wr0_en = 1; wr0_addr = '0; wr0_data = 32'hFFFF_FFFF;
        rsv_en = 1; rsv_addr = '0;
        cycle();
        idle();
        for (int i = 0; i < NUM_RD; i++) set_read(i, 0);
        cycle();
        for (int i = 0; i < NUM_RD; i++) begin
            checks++;
            if (port_data(i) !== '0 || rd_busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL zero_reg port%0d: got data=%h busy=%b, want 0/0", i, port_data(i), rd_busy[i]);
            end
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en = 1; rsv_addr = 5'd9;
        cycle();
        idle();
        set_read(0, 9);
        cycle();
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reserve_busy: got %b, want 1", rd_busy[0]);
        end
        idle();
        wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'h42;
        set_read(0, 9);
        cycle();
        checks++;
        if (port_data(0) !== 32'h42 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL writeback_clear: got data=%h busy=%b, want 42/0", port_data(0), rd_busy[0]);
        end
        idle();
        rsv_en = 1; rsv_addr = 5'd9;
        wr0_en = 1; wr0_addr = 5'd9; wr0_data = 32'h77;
        set_read(0, 9);
        cycle();
        checks++;
        if (port_data(0) !== 32'h77 || rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reserve_over_write: got data=%h busy=%b, want 77/1", port_data(0), rd_busy[0]);
        end
    endtask

    task automatic test_hold();
        idle();
        wr1_en = 1; wr1_addr = 5'd9; wr1_data = 32'h55;
        cycle();
        checks++;
        if (rd_valid[0] !== 1'b0 || port_data(0) !== 32'h77 || rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL hold: got valid=%b data=%h busy=%b, want 0/77/1", rd_valid[0], port_data(0), rd_busy[0]);
        end
    endtask

    task automatic compare_all_ports_random(input int n);
        for (int i = 0; i < NUM_RD; i++) begin
            checks++;
            if (rd_valid[i] !== exp_valid[i] || port_data(i) !== exp_data[i] || rd_busy[i] !== exp_busy[i]) begin
                errors++;
                $display("FAIL random[%0d] port%0d: got valid=%b data=%h busy=%b, want %b/%h/%b",
                         n, i, rd_valid[i], port_data(i), rd_busy[i], exp_valid[i], exp_data[i], exp_busy[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            rst      = ($urandom_range(0, 49) == 0);
            rd_en    = NUM_RD'($urandom);
            for (int i = 0; i < NUM_RD; i++)
                rd_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 11));
            wr0_en   = $urandom_range(0, 1) == 1;
            wr0_addr = ADDR_W'($urandom_range(0, 11));
            wr0_data = $urandom;
            wr1_en   = $urandom_range(0, 1) == 1;
            wr1_addr = ADDR_W'($urandom_range(0, 11));
            wr1_data = $urandom;
            rsv_en   = $urandom_range(0, 2) == 0;
            rsv_addr = ADDR_W'($urandom_range(0, 11));
            cycle();
            compare_all_ports_random(n);
        end
    endtask

    task automatic test_reset_midstream();
        idle();
        for (int r = 1; r < NUM_REGS; r += 2) begin
            wr0_en = 1; wr0_addr = ADDR_W'(r); wr0_data = DATA_W'(r);
            wr1_en = (r + 1 < NUM_REGS); wr1_addr = ADDR_W'(r + 1); wr1_data = DATA_W'(r + 1);
            for (int i = 0; i < NUM_RD; i++) set_read(i, r + i);
            cycle();
        end
        idle();
        set_read(0, 30);
        set_read(1, 17);
        cycle();
        checks++;
        if (port_data(0) !== 32'd30 || port_data(1) !== 32'd17) begin
            errors++;
            $display("FAIL fill_readback: got %h %h, want 1e 11", port_data(0), port_data(1));
        end
        rst = 1;
        cycle();
        for (int i = 0; i < NUM_RD; i++) begin
            checks++;
            if (rd_valid[i] !== 1'b0 || port_data(i) !== '0) begin
                errors++;
                $display("FAIL midstream_reset port%0d: got valid=%b data=%h, want 0/0", i, rd_valid[i], port_data(i));
            end
        end
        for (int r = 1; r < NUM_REGS; r += 5) begin
            idle();
            for (int i = 0; i < NUM_RD; i++) set_read(i, r + i);
            cycle();
            for (int i = 0; i < NUM_RD; i++) begin
                checks++;
                if (rd_valid[i] !== 1'b1 || port_data(i) !== '0) begin
                    errors++;
                    $display("FAIL cleared_reg r%0d port%0d: got valid=%b data=%h, want 1/0",
                             r + i, i, rd_valid[i], port_data(i));
                end
            end
        end
    endtask

    initial begin
        idle();
        for (int r = 0; r < NUM_REGS; r++) begin m_reg[r] = '0; m_busy[r] = 0; end
        @(negedge clk);
        test_reset();
        test_bypass();
        test_same_addr();
        test_zero_reg();
        test_scoreboard();
        test_hold();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
